inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning words of program storage (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 1, meaning request-accept to earliest response-valid, in cycles (1..4).
REQ-003 SHALL have parameter RSP_DEPTH, default 4, meaning response buffer entries (>= LATENCY+1).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of word 0.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  meaning synchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  1  meaning a fetch request is present.
REQ-008 SHALL have port req_ready  out  1  meaning the block can accept a fetch this cycle.
REQ-009 SHALL have port req_addr  in  32  meaning the fetch byte address.
REQ-010 SHALL have port rsp_valid  out  1  meaning a response is presented.
REQ-011 SHALL have port rsp_ready  in  1  meaning the consumer takes the response.
REQ-012 SHALL have port rsp_data  out  32  meaning the instruction word.
REQ-013 SHALL have port rsp_fault  out  2  meaning 00 ok, 01 misaligned, 10 out-of-range.
REQ-014 SHALL have port rsp_addr  out  32  meaning the echoed request address.
REQ-015 SHALL have port flush  in  1  meaning discard all in-flight and buffered responses.
REQ-016 SHALL have port ld_en  in  1  meaning a program-load write strobe.
REQ-017 SHALL have port ld_addr  in  32  meaning the load byte address.
REQ-018 SHALL have port ld_data  in  32  meaning the load word.

Function
REQ-019 SHALL accept a request only on req_valid && req_ready; responses SHALL return in request order.
REQ-020 SHALL assert rsp_valid for an accepted request no earlier than LATENCY cycles after acceptance, exactly LATENCY when the buffer is empty and rsp_ready is high.
REQ-021 SHALL drive req_ready = !ld_en && (in-flight + buffered) < RSP_DEPTH, so a stalled consumer never loses a response.
REQ-022 SHALL hold rsp_valid, rsp_data, rsp_fault and rsp_addr stable while rsp_valid && !rsp_ready.
REQ-023 SHALL use word index = (req_addr - BASE_ADDR) >> 2, with the subtraction modulo 2^32.
REQ-024 SHALL report fault 01 with data 32'h0 when req_addr[1:0] != 0.
REQ-025 SHALL report fault 10 with data 32'h0 when the word index >= DEPTH_WORDS and the address is aligned; misaligned SHALL take priority.
REQ-026 SHALL make storage read as 32'h00000000 (nop) at every word after reset until it is loaded.
REQ-027 SHALL write ld_data on ld_en when ld_addr is aligned and in range, otherwise SHALL ignore the write silently.
REQ-028 SHALL return pre-write data for a read that samples storage in the same cycle as a write to that word.
REQ-029 SHALL apply flush in its cycle by clearing every pipeline stage and buffer entry, forcing rsp_valid to 0 the next cycle.
REQ-030 SHALL treat a request accepted in the flush cycle as post-flush and return it normally.
REQ-031 SHALL make flush take priority over a concurrent rsp_ready handshake; a response presented in the flush cycle and taken by the consumer counts as delivered.
REQ-032 SHALL make simultaneous accept and dequeue with a full buffer legal and never overflow.

Reset
REQ-033 SHALL, while rst_n is low at a clock edge, clear pipeline valids and buffer pointers and counters, and drive rsp_valid 0, rsp_data 0, rsp_fault 00, rsp_addr 0 and req_ready 0.
REQ-034 SHALL zero storage contents on reset, either by a sequenced clear (req_ready low until done, at most DEPTH_WORDS cycles) or by a per-word valid-bit clear.
REQ-035 SHALL let reset asserted mid-operation abandon all in-flight requests without emitting any response.

Structure
REQ-036 SHALL place the fault-code typedef (FETCH_OK, FETCH_MISALIGN, FETCH_OOR) and the response struct {data, addr, fault} in the shared package mips_pkg.
REQ-037 SHALL instantiate the ordered response buffer as one sub-module, fetch_rsp_fifo, parameterised by RSP_DEPTH and the struct type.

Verification
REQ-038 Bench SHALL cover: load 0x34080032 at byte 0x00 and 0xac080000 at 0x04, then fetch 0x00 and 0x04 back-to-back with LATENCY=2 -> responses in order at cycles +2 and +3, fault 00.
REQ-039 Bench SHALL cover: fetch 0x06 -> data 0, fault 01; fetch byte 0x800 with DEPTH_WORDS=512 -> data 0, fault 10.
REQ-040 Bench SHALL cover: hold rsp_ready=0 and issue requests continuously -> exactly RSP_DEPTH accepted, then req_ready=0; release -> all delivered in order with none lost.
REQ-041 Bench SHALL cover: three requests in flight plus flush with a concurrent request to 0x1A0 -> only the 0x1A0 response is emitted.
REQ-042 Bench SHALL cover: ld_en to 0x10 in the same cycle a fetch of 0x10 samples storage -> old data returned; the next fetch returns the new data.
REQ-043 Bench SHALL cover: rst_n low for one cycle with two requests pending -> no responses, rsp_valid=0, and a later fetch of any address returns 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: types shared by the instruction fetch memory and its response
// buffer.
//   fetch_fault_e  : response status (ok / misaligned / out-of-range)
//   fetch_rsp_t    : one response {data, addr, fault}
//   fetch_classify : status of a byte address against a word window
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH_OK       = 2'b00,
    FETCH_MISALIGN = 2'b01,
    FETCH_OOR      = 2'b10
  } fetch_fault_e;

  typedef struct packed {
    logic [31:0]  data;
    logic [31:0]  addr;
    fetch_fault_e fault;
  } fetch_rsp_t;

  // Misalignment wins over range; the offset wraps modulo 2^32 so an address
  // below the base lands far out of range rather than aliasing into storage.
  function automatic fetch_fault_e fetch_classify(input logic [31:0] addr,
                                                  input logic [31:0] base,
                                                  input int unsigned depth_words);
    if (addr[1:0] != 2'b00) return FETCH_MISALIGN;
    if (((addr - base) >> 2) >= depth_words) return FETCH_OOR;
    return FETCH_OK;
  endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// fetch_rsp_fifo: ordered response buffer for inst_fetch_mem.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop every entry; a push in the same cycle is kept
//   push, din  : enqueue one entry
//   pop        : dequeue the head (ignored when empty)
//   valid      : buffer holds at least one entry
//   dout       : head entry, stable until popped
// The owner guarantees push never exceeds DEPTH outstanding entries.
module fetch_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [65:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic valid,
  output T     dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (cnt != '0);
  assign pop_eff = pop && valid;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      cnt    <= push ? CW'(1) : '0;
    end else begin
      if (push)    wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop_eff);
    end
  end

  // On flush the surviving push restarts the buffer at slot 0.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: program storage with a valid/ready fetch port, in-order
// responses after a fixed pipeline latency, and a program-load write port.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/ready/addr : fetch request (byte address)
//   rsp_valid/ready      : response handshake
//   rsp_data/fault/addr  : instruction word, status, echoed address
//   flush                : discard everything in flight or buffered
//   ld_en/addr/data      : program-load write strobe
module inst_fetch_mem
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 512,
  parameter int          LATENCY     = 1,
  parameter int          RSP_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_fault,
  output logic [31:0] rsp_addr,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int OW = $clog2(RSP_DEPTH + 1);

  logic [31:0]            mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] word_vld;
  logic [OW-1:0]          occ;
  logic                   acc;
  logic                   pop;
  logic                   ld_ok;
  fetch_fault_e           acc_fault;
  logic                   push_v;
  logic [31:0]            push_addr;
  fetch_fault_e           push_fault;
  logic [IW-1:0]          rd_idx;
  fetch_rsp_t             push_rsp;
  logic                   fifo_valid;
  fetch_rsp_t             fifo_dout;

  function automatic logic [IW-1:0] word_index(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // occ counts pipeline plus buffer, so every accepted request already owns
  // a buffer slot and a stalled consumer can never cause an overflow.
  assign req_ready = rst_n && !ld_en && (occ < OW'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;
  assign pop       = fifo_valid && rsp_ready;
  assign acc_fault = fetch_classify(req_addr, BASE_ADDR, DEPTH_WORDS);
  assign ld_ok     = ld_en && (fetch_classify(ld_addr, BASE_ADDR, DEPTH_WORDS) == FETCH_OK);

  always_ff @(posedge clk) begin
    if (!rst_n)     occ <= '0;
    else if (flush) occ <= OW'(acc);
    else            occ <= occ + OW'(acc) - OW'(pop);
  end

  // Storage contents are never reset; a cleared per-word valid bit makes an
  // unloaded word read as zero (nop).
  always_ff @(posedge clk) begin
    if (ld_ok) mem[word_index(ld_addr)] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     word_vld <= '0;
    else if (ld_ok) word_vld[word_index(ld_addr)] <= 1'b1;
  end

  // Requests travel LATENCY-1 register stages; storage is read in the cycle
  // the response enters the buffer, so a same-cycle load yields old data.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v     = acc;
      assign push_addr  = req_addr;
      assign push_fault = acc_fault;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] st_v;
      logic [31:0]   st_addr  [NS];
      fetch_fault_e  st_fault [NS];

      // A request accepted in the flush cycle is post-flush and survives.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          st_v <= '0;
        end else begin
          for (int k = NS - 1; k > 0; k--) st_v[k] <= flush ? 1'b0 : st_v[k-1];
          st_v[0] <= acc;
        end
      end

      always_ff @(posedge clk) begin
        st_addr[0]  <= req_addr;
        st_fault[0] <= acc_fault;
        for (int k = 1; k < NS; k++) begin
          st_addr[k]  <= st_addr[k-1];
          st_fault[k] <= st_fault[k-1];
        end
      end

      assign push_v     = st_v[NS-1] && !flush;
      assign push_addr  = st_addr[NS-1];
      assign push_fault = st_fault[NS-1];
    end
  endgenerate

  assign rd_idx = word_index(push_addr);

  always_comb begin
    push_rsp.addr  = push_addr;
    push_rsp.fault = push_fault;
    push_rsp.data  = '0;
    if (push_fault == FETCH_OK && word_vld[rd_idx]) push_rsp.data = mem[rd_idx];
  end

  fetch_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (fetch_rsp_t)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_v),
    .din   (push_rsp),
    .pop   (pop),
    .valid (fifo_valid),
    .dout  (fifo_dout)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_data  = fifo_valid ? fifo_dout.data  : 32'h0;
  assign rsp_addr  = fifo_valid ? fifo_dout.addr  : 32'h0;
  assign rsp_fault = fifo_valid ? fifo_dout.fault : FETCH_OK;

endmodule

// File: tb/tb_inst_fetch_mem.sv
module tb_inst_fetch_mem;

  localparam int LAT = 2;
  localparam int RD  = 4;
  localparam int DW  = 512;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, flush, ld_en;
  logic [31:0] req_addr, rsp_data, rsp_addr, ld_addr, ld_data;
  logic [1:0]  rsp_fault;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  fault;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [DW];
  logic [31:0] t_addr [6] = '{32'h6, 32'h800, 32'h7fc, 32'h7ff, 32'hfffffffc, 32'h4};
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  bit          chk_lat = 1'b0;
  int          a0, r0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_fetch_mem #(
    .DEPTH_WORDS (DW),
    .LATENCY     (LAT),
    .RSP_DEPTH   (RD),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .rsp_addr  (rsp_addr),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || rsp_valid) && k < 64) begin
      tick();
      k++;
    end
    check(tag, 32'(k < 64), 32'd1);
  endtask

  // Scoreboard: expectations are pushed at the negedge of the accepting cycle
  // and popped on each response handshake; the reference memory mirrors loads.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < DW; i++) ref_mem[i] = 32'h0;
    end else begin
      if (rsp_valid) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("rsp_data", rsp_data, sb[0].data);
          check("rsp_addr", rsp_addr, sb[0].addr);
          check("rsp_fault", 32'(rsp_fault), 32'(sb[0].fault));
          if (rsp_ready) begin
            if (sb[0].chk) check("rsp_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
          end
        end
        if (rsp_ready) n_rsp++;
      end
      if (flush) sb.delete();
      if (req_valid && req_ready) begin
        e.addr = req_addr;
        e.cyc  = cyc + LAT;
        e.chk  = chk_lat;
        if (req_addr[1:0] != 2'b00)      e.fault = 2'b01;
        else if (req_addr >= 32'(DW * 4)) e.fault = 2'b10;
        else                              e.fault = 2'b00;
        e.data = (e.fault == 2'b00) ? ref_mem[req_addr[10:2]] : 32'h0;
        sb.push_back(e);
        n_acc++;
      end
      if (ld_en && ld_addr[1:0] == 2'b00 && ld_addr < 32'(DW * 4))
        ref_mem[ld_addr[10:2]] = ld_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_rsp_addr", rsp_addr, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // program load, including two writes that must be ignored
    ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'h34080032;
    #1 check("ready_low_on_ld", 32'(req_ready), 32'd0);
    tick();
    ld_addr = 32'h4;   ld_data = 32'hac080000; tick();
    ld_addr = 32'h2;   ld_data = 32'hdeadbeef; tick();
    ld_addr = 32'h800; ld_data = 32'hbad0bad0; tick();
    ld_en = 1'b0;

    // back-to-back fetch, exact latency
    a0 = n_acc; r0 = n_rsp;
    chk_lat = 1'b1; req_valid = 1'b1;
    req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0; chk_lat = 1'b0;
    drain("drain_b2b");
    check("b2b_acc", n_acc - a0, 32'd2);
    check("b2b_rsp", n_rsp - r0, 32'd2);

    // faults and range boundaries
    r0 = n_rsp; req_valid = 1'b1;
    foreach (t_addr[i]) begin
      req_addr = t_addr[i];
      tick();
    end
    req_valid = 1'b0;
    drain("drain_fault");
    check("fault_rsp", n_rsp - r0, 32'd6);

    // stalled consumer: buffer fills, then everything drains in order
    a0 = n_acc; r0 = n_rsp; rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    check("stall_acc", n_acc - a0, 32'(RD));
    check("stall_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    drain("drain_stall");
    check("stall_rsp", n_rsp - r0, 32'(RD));

    // response taken in the flush cycle counts as delivered
    r0 = n_rsp; req_valid = 1'b1; req_addr = 32'h4; tick();
    req_valid = 1'b0; tick();
    check("pre_flush_valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_hs_valid_off", 32'(rsp_valid), 32'd0);
    drain("drain_flush_hs");
    check("flush_hs_rsp", n_rsp - r0, 32'd1);

    // three in flight, flush with a concurrent request
    r0 = n_rsp; rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'h8;  tick();
    req_addr = 32'hc;  tick();
    req_addr = 32'h10; tick();
    flush = 1'b1; req_addr = 32'h1a0; tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_clears", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    drain("drain_flush");
    check("flush_one_rsp", n_rsp - r0, 32'd1);

    // load landing in the cycle the fetch samples storage
    ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'h11111111; tick();
    ld_en = 1'b0;
    r0 = n_rsp; req_valid = 1'b1; req_addr = 32'h10; tick();
    req_valid = 1'b0; ld_en = 1'b1; ld_data = 32'h22222222; tick();
    ld_en = 1'b0; req_valid = 1'b1; tick();
    req_valid = 1'b0;
    drain("drain_wr_rd");
    check("wr_rd_rsp", n_rsp - r0, 32'd2);

    // reset mid-operation
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    r0 = n_rsp; rsp_ready = 1'b1;
    repeat (4) tick();
    check("rst_no_rsp", n_rsp - r0, 32'd0);
    req_valid = 1'b1;
    req_addr = 32'h0;  tick();
    req_addr = 32'h4;  tick();
    req_addr = 32'h10; tick();
    req_valid = 1'b0;
    drain("drain_post_rst");
    check("rst_post_rsp", n_rsp - r0, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
